// File: rtl/cache_control_pwb.sv
// N-way cache controller FSM: CPU hit/miss handling with write-back or write-through policy,
// plus a full-cache flush sweep driven by a level request / done-pulse handshake.
module cache_control_pwb #(
    parameter int unsigned S_INDEX       = 4,
    parameter int unsigned S_WAY         = 1,
    parameter int unsigned WRITE_THROUGH = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               mem_resp,
    input  logic               pmem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    input  logic               is_hit,
    input  logic [S_WAY-1:0]   hit_way,
    input  logic [S_WAY-1:0]   plru_way,
    input  logic               is_dirty,
    output logic [S_WAY-1:0]   way_sel,
    output logic [1:0]         addr_sel,
    output logic [S_INDEX-1:0] flush_set,
    output logic               is_allocate,
    output logic               load_data,
    output logic               load_tag,
    output logic               load_valid,
    output logic               load_dirty,
    output logic               load_plru,
    output logic               valid_in,
    output logic               dirty_in,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done
);

    localparam bit WT = (WRITE_THROUGH != 0);

    typedef enum logic [2:0] {
        IDLE,
        TAG_COMPARE,
        WRITE_BACK,
        ALLOCATE,
        WT_WRITE,
        FLUSH_CHECK,
        FLUSH_WB,
        FLUSH_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [S_INDEX-1:0] flush_set_q, flush_set_d;
    logic [S_WAY-1:0]   flush_way_q, flush_way_d;
    logic [S_WAY-1:0]   wt_way_q, wt_way_d;

    logic               last_line;
    logic [S_INDEX-1:0] next_set;
    logic [S_WAY-1:0]   next_way;

    // Way is the inner index; a wrapping way carries into the set index.
    always_comb begin
        last_line = (flush_set_q == '1) && (flush_way_q == '1);
        next_way  = flush_way_q + 1'b1;
        next_set  = (flush_way_q == '1) ? flush_set_q + 1'b1 : flush_set_q;
    end

    // Outputs decode state together with same-cycle datapath inputs, since
    // TAG_COMPARE must answer in the cycle the tag result is presented.
    always_comb begin
        state_d     = state_q;
        flush_set_d = flush_set_q;
        flush_way_d = flush_way_q;
        wt_way_d    = wt_way_q;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        way_sel     = '0;
        addr_sel    = 2'd0;
        is_allocate = 1'b0;
        load_data   = 1'b0;
        load_tag    = 1'b0;
        load_valid  = 1'b0;
        load_dirty  = 1'b0;
        load_plru   = 1'b0;
        valid_in    = 1'b0;
        dirty_in    = 1'b0;
        flush_busy  = 1'b0;
        flush_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = TAG_COMPARE;
                end else if (flush_req) begin
                    flush_set_d = '0;
                    flush_way_d = '0;
                    state_d     = WT ? FLUSH_DONE : FLUSH_CHECK;
                end
            end

            TAG_COMPARE: begin
                way_sel = is_hit ? hit_way : plru_way;
                if (is_hit) begin
                    load_plru = 1'b1;
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        if (WT) begin
                            dirty_in = 1'b0;
                            wt_way_d = hit_way;
                            state_d  = WT_WRITE;
                        end else begin
                            dirty_in = 1'b1;
                            mem_resp = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        mem_resp = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (is_dirty && !WT) begin
                    state_d = WRITE_BACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end

            WRITE_BACK: begin
                pmem_write = 1'b1;
                addr_sel   = 2'd1;
                way_sel    = plru_way;
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read   = 1'b1;
                is_allocate = 1'b1;
                way_sel     = plru_way;
                load_data   = 1'b1;
                load_tag    = 1'b1;
                load_valid  = 1'b1;
                load_dirty  = 1'b1;
                valid_in    = 1'b1;
                dirty_in    = 1'b0;
                if (pmem_resp) begin
                    state_d = TAG_COMPARE;
                end
            end

            WT_WRITE: begin
                pmem_write = 1'b1;
                way_sel    = wt_way_q;
                if (pmem_resp) begin
                    mem_resp = 1'b1;
                    state_d  = IDLE;
                end
            end

            FLUSH_CHECK: begin
                flush_busy = 1'b1;
                addr_sel   = 2'd2;
                way_sel    = flush_way_q;
                if (is_dirty) begin
                    state_d = FLUSH_WB;
                end else begin
                    flush_set_d = next_set;
                    flush_way_d = next_way;
                    if (last_line) begin
                        state_d = FLUSH_DONE;
                    end
                end
            end

            FLUSH_WB: begin
                flush_busy = 1'b1;
                pmem_write = 1'b1;
                addr_sel   = 2'd2;
                way_sel    = flush_way_q;
                if (pmem_resp) begin
                    load_dirty  = 1'b1;
                    dirty_in    = 1'b0;
                    flush_set_d = next_set;
                    flush_way_d = next_way;
                    state_d     = last_line ? FLUSH_DONE : FLUSH_CHECK;
                end
            end

            FLUSH_DONE: begin
                flush_busy = 1'b1;
                flush_done = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign flush_set = flush_set_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_set_q <= '0;
            flush_way_q <= '0;
            wt_way_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_set_q <= flush_set_d;
            flush_way_q <= flush_way_d;
            wt_way_q    <= wt_way_d;
        end
    end

endmodule

// File: tb/tb_cache_control_pwb.sv
// Bench for cache_control_pwb: a write-back and a write-through instance (4 sets, 2 ways)
// share stimulus; each vector names the instance it checks.
module tb_cache_control_pwb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_read, mem_write, pmem_resp, is_hit, is_dirty, flush_req;
    logic [0:0] hit_way, plru_way;

    logic [1:0] mem_resp, pmem_read, pmem_write, is_allocate, load_data, load_tag;
    logic [1:0] load_valid, load_dirty, load_plru, valid_in, dirty_in;
    logic [1:0] flush_busy, flush_done, way_sel;
    logic [1:0][1:0] addr_sel, flush_set;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_control_pwb #(
            .S_INDEX(2),
            .S_WAY(1),
            .WRITE_THROUGH(g)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .mem_read(mem_read),
            .mem_write(mem_write),
            .mem_resp(mem_resp[g]),
            .pmem_resp(pmem_resp),
            .pmem_read(pmem_read[g]),
            .pmem_write(pmem_write[g]),
            .is_hit(is_hit),
            .hit_way(hit_way),
            .plru_way(plru_way),
            .is_dirty(is_dirty),
            .way_sel(way_sel[g]),
            .addr_sel(addr_sel[g]),
            .flush_set(flush_set[g]),
            .is_allocate(is_allocate[g]),
            .load_data(load_data[g]),
            .load_tag(load_tag[g]),
            .load_valid(load_valid[g]),
            .load_dirty(load_dirty[g]),
            .load_plru(load_plru[g]),
            .valid_in(valid_in[g]),
            .dirty_in(dirty_in[g]),
            .flush_req(flush_req),
            .flush_busy(flush_busy[g]),
            .flush_done(flush_done[g])
        );
    end

    localparam logic [12:0] oMR  = 13'd1 << 0;
    localparam logic [12:0] oPR  = 13'd1 << 1;
    localparam logic [12:0] oPW  = 13'd1 << 2;
    localparam logic [12:0] oAL  = 13'd1 << 3;
    localparam logic [12:0] oLDA = 13'd1 << 4;
    localparam logic [12:0] oLT  = 13'd1 << 5;
    localparam logic [12:0] oLV  = 13'd1 << 6;
    localparam logic [12:0] oLDY = 13'd1 << 7;
    localparam logic [12:0] oLP  = 13'd1 << 8;
    localparam logic [12:0] oVI  = 13'd1 << 9;
    localparam logic [12:0] oDI  = 13'd1 << 10;
    localparam logic [12:0] oFB  = 13'd1 << 11;
    localparam logic [12:0] oFD  = 13'd1 << 12;
    localparam logic [12:0] ALLOC = oPR | oAL | oLDA | oLT | oLV | oLDY | oVI;

    localparam int unsigned iRST = 1, iRD = 2, iWR = 4, iPR = 8;
    localparam int unsigned iHIT = 16, iDY = 32, iFQ = 64, iNC = 128;

    typedef struct {
        int unsigned inst;
        int unsigned inm;
        logic        hw;
        logic        pw;
        logic [12:0] fl;
        logic        ew;
        logic [1:0]  ea;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;
    int   pw_rises = 0;
    int   fd_cnt   = 0;
    logic pw_prev  = 1'b0;

    function automatic vec_t mk(input int unsigned inst, input int unsigned inm,
                                input logic hw, input logic pw, input logic [12:0] fl,
                                input logic ew, input logic [1:0] ea, input logic [1:0] es);
        vec_t v;
        v.inst = inst; v.inm = inm; v.hw = hw; v.pw = pw;
        v.fl = fl; v.ew = ew; v.ea = ea; v.es = es;
        return v;
    endfunction

    task automatic add(input int unsigned inst, input int unsigned inm,
                       input logic hw, input logic pw, input logic [12:0] fl,
                       input logic ew, input logic [1:0] ea, input logic [1:0] es);
        tbl.push_back(mk(inst, inm, hw, pw, fl, ew, ea, es));
    endtask

    function automatic logic [12:0] act_flags(input int unsigned i);
        return {flush_done[i], flush_busy[i], dirty_in[i], valid_in[i], load_plru[i],
                load_dirty[i], load_valid[i], load_tag[i], load_data[i], is_allocate[i],
                pmem_write[i], pmem_read[i], mem_resp[i]};
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock cycle: drive at negedge, sample 2ns later, then wait for the rising edge.
    task automatic cyc(input vec_t v, input string name);
        logic [12:0] af;
        int unsigned i;
        @(negedge clk);
        rst       = (v.inm & iRST) != 0;
        mem_read  = (v.inm & iRD)  != 0;
        mem_write = (v.inm & iWR)  != 0;
        pmem_resp = (v.inm & iPR)  != 0;
        is_hit    = (v.inm & iHIT) != 0;
        is_dirty  = (v.inm & iDY)  != 0;
        flush_req = (v.inm & iFQ)  != 0;
        hit_way   = v.hw;
        plru_way  = v.pw;
        #2;
        if (pmem_write[0] && !pw_prev) pw_rises++;
        pw_prev = pmem_write[0];
        if (flush_done[0]) fd_cnt++;
        if ((v.inm & iNC) == 0) begin
            i  = v.inst;
            af = act_flags(i);
            total++;
            if (af == v.fl && way_sel[i] == v.ew && addr_sel[i] == v.ea && flush_set[i] == v.es)
                passed++;
            else
                $display("FAIL %s (inst %0d): got flags=%h way=%0d addr=%0d fset=%0d, expected flags=%h way=%0d addr=%0d fset=%0d",
                         name, i, af, way_sel[i], addr_sel[i], flush_set[i], v.fl, v.ew, v.ea, v.es);
        end
        @(posedge clk);
    endtask

    logic dmap [4][2];

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        is_hit = 1'b0; is_dirty = 1'b0; flush_req = 1'b0; hit_way = '0; plru_way = '0;

        // Reset with mem_read held, then read hit
        add(0, iRST | iNC,        0, 0, '0, 0, 0, 0);
        add(0, iRST | iRD,        0, 0, '0, 0, 0, 0);
        add(0, iRST | iRD,        0, 0, '0, 0, 0, 0);
        add(0, iRD,               0, 0, '0, 0, 0, 0);
        add(0, iRD | iHIT,        1, 0, oMR | oLP, 1, 0, 0);
        add(0, 0,                 0, 0, '0, 0, 0, 0);
        // WB write miss to dirty victim way 1
        add(0, iWR,               0, 1, '0, 0, 0, 0);
        add(0, iWR | iDY,         0, 1, '0, 1, 0, 0);
        add(0, iWR,               0, 1, oPW, 1, 1, 0);
        add(0, iWR,               0, 1, oPW, 1, 1, 0);
        add(0, iWR | iPR,         0, 1, oPW, 1, 1, 0);
        add(0, iWR,               0, 1, ALLOC, 1, 0, 0);
        add(0, iWR,               0, 1, ALLOC, 1, 0, 0);
        add(0, iWR | iPR,         0, 1, ALLOC, 1, 0, 0);
        add(0, iWR | iHIT,        1, 1, oMR | oLP | oLDA | oLDY | oDI, 1, 0, 0);
        add(0, 0,                 0, 0, '0, 0, 0, 0);
        // WT write hit way 0, then dirty-flagged miss still allocates
        add(1, iRST | iNC,        0, 0, '0, 0, 0, 0);
        add(1, iWR,               0, 1, '0, 0, 0, 0);
        add(1, iWR | iHIT,        0, 1, oLDA | oLP | oLDY, 0, 0, 0);
        add(1, iWR,               1, 1, oPW, 0, 0, 0);
        add(1, iWR | iPR,         1, 1, oPW | oMR, 0, 0, 0);
        add(1, 0,                 0, 0, '0, 0, 0, 0);
        add(1, iRD,               0, 1, '0, 0, 0, 0);
        add(1, iRD | iDY,         0, 1, '0, 1, 0, 0);
        add(1, iRD | iPR | iDY,   0, 1, ALLOC, 1, 0, 0);
        add(1, iRD | iHIT,        1, 1, oMR | oLP, 1, 0, 0);
        add(1, 0,                 0, 0, '0, 0, 0, 0);
        // WT flush completes immediately
        add(1, iFQ,               0, 0, '0, 0, 0, 0);
        add(1, iFQ,               0, 0, oFD | oFB, 0, 0, 0);
        add(1, 0,                 0, 0, '0, 0, 0, 0);
        // CPU request beats simultaneous flush; CPU ignored and stray pmem_resp ignored while flushing
        add(0, iRST | iNC,        0, 0, '0, 0, 0, 0);
        add(0, iRD | iFQ,         0, 0, '0, 0, 0, 0);
        add(0, iRD | iFQ | iHIT,  0, 0, oMR | oLP, 0, 0, 0);
        add(0, iFQ,               0, 0, '0, 0, 0, 0);
        add(0, iFQ,               0, 0, oFB, 0, 2, 0);
        add(0, iFQ | iPR,         0, 0, oFB, 1, 2, 0);
        add(0, iFQ | iRD,         0, 0, oFB, 0, 2, 1);

        for (int k = 0; k < tbl.size(); k++) cyc(tbl[k], $sformatf("vec%0d", k));

        // Full WB sweep with dirty lines at (set1,way0) and (set3,way1)
        foreach (dmap[s, w]) dmap[s][w] = 1'b0;
        dmap[1][0] = 1'b1;
        dmap[3][1] = 1'b1;
        cyc(mk(0, iRST | iNC, 0, 0, '0, 0, 0, 0), "F_rst");
        pw_rises = 0;
        fd_cnt   = 0;
        cyc(mk(0, iFQ, 0, 0, '0, 0, 0, 0), "F_accept");
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                cyc(mk(0, iFQ | (dmap[s][w] ? iDY : 0), 0, 0, oFB, 1'(w), 2, 2'(s)), "F_check");
                if (dmap[s][w]) begin
                    for (int k = 0; k < 3; k++)
                        cyc(mk(0, iFQ | (k == 2 ? iPR : 0), 0, 0,
                               oFB | oPW | (k == 2 ? oLDY : 13'd0), 1'(w), 2, 2'(s)), "F_wb");
                end
            end
        end
        cyc(mk(0, iFQ, 0, 0, oFB | oFD, 0, 0, 0), "F_done");
        cyc(mk(0, 0,   0, 0, '0, 0, 0, 0), "F_idle");
        check_int("F_pmem_write_transfers", pw_rises, 2);
        check_int("F_flush_done_pulses", fd_cnt, 1);

        // Reset during FLUSH_WB at set 2, then restart from set 0 way 0
        cyc(mk(0, iRST | iNC, 0, 0, '0, 0, 0, 0), "G_rst0");
        fd_cnt = 0;
        cyc(mk(0, iFQ, 0, 0, '0, 0, 0, 0), "G_accept");
        for (int k = 0; k < 4; k++)
            cyc(mk(0, iFQ, 0, 0, oFB, 1'(k % 2), 2, 2'(k / 2)), "G_check");
        cyc(mk(0, iFQ | iDY,  0, 0, oFB, 0, 2, 2), "G_check_dirty");
        cyc(mk(0, iFQ,        0, 0, oFB | oPW, 0, 2, 2), "G_wb");
        cyc(mk(0, iFQ | iRST, 0, 0, oFB | oPW, 0, 2, 2), "G_rst_in_wb");
        cyc(mk(0, 0,          0, 0, '0, 0, 0, 0), "G_after_rst");
        cyc(mk(0, iFQ,        0, 0, '0, 0, 0, 0), "G_reaccept");
        cyc(mk(0, iFQ,        0, 0, oFB, 0, 2, 0), "G_restart");
        check_int("G_no_flush_done", fd_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
